decode_execute: RTL and testbench

DECODE_EXECUTE -- requirements
Module: decode_execute

---
 rtl/decode_execute.sv | 171 +++++++++++++++++
 tb/tb_decode_execute.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute.sv
// RV32I decode + execute stage: combinational decode and ALU, then one register
// stage so every output appears one cycle after its inputs are sampled.
module decode_execute (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        out_valid,
    output logic [31:0] alu_result,
    output logic [31:0] imm_ext,
    output logic [3:0]  alu_control,
    output logic        alu_src,
    output logic [1:0]  pc_src,
    output logic [2:0]  result_src,
    output logic [2:0]  instruction_type
);

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_SLL = 4'd2,  ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7,
        ALU_OR = 4'd8,   ALU_AND = 4'd9,  ALU_EQ = 4'd10,  ALU_NE = 4'd11,
        ALU_GE = 4'd12,  ALU_GEU = 4'd13, ALU_NOP = 4'd14
    } alu_e;

    typedef enum logic [2:0] {
        TYPE_R = 3'd0, TYPE_I = 3'd1, TYPE_S = 3'd2, TYPE_B = 3'd3,
        TYPE_U = 3'd4, TYPE_J = 3'd5, TYPE_INV = 3'd6
    } itype_e;

    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign op       = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7_5 = instr[30];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {instr[31:12], 12'b0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    function automatic alu_e arith_ctrl(input logic [2:0] f3, input logic f7, input logic is_reg);
        case (f3)
            3'b000:  return (is_reg && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    alu_e        alu_ctrl_d;
    itype_e      itype_d;
    logic [31:0] imm_d;
    logic        alu_src_d;
    logic [1:0]  pc_src_d;
    logic [2:0]  result_src_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        alu_ctrl_d   = ALU_ADD;
        itype_d      = TYPE_INV;
        imm_d        = '0;
        alu_src_d    = 1'b0;
        pc_src_d     = 2'd0;
        result_src_d = 3'd0;
        case (opcode_e'(op))
            OP_LUI:    begin itype_d = TYPE_U; imm_d = imm_u; result_src_d = 3'd1; end
            OP_AUIPC:  begin itype_d = TYPE_U; imm_d = imm_u; result_src_d = 3'd2; end
            OP_JAL:    begin itype_d = TYPE_J; imm_d = imm_j; result_src_d = 3'd3; pc_src_d = 2'd1; end
            OP_JALR: begin
                itype_d = TYPE_I; imm_d = imm_i; alu_src_d = 1'b1;
                result_src_d = 3'd3; pc_src_d = 2'd2;
            end
            OP_BRANCH: begin
                itype_d  = TYPE_B;
                imm_d    = imm_b;
                pc_src_d = 2'd3;
                case (funct3)
                    3'b000:  alu_ctrl_d = ALU_EQ;
                    3'b001:  alu_ctrl_d = ALU_NE;
                    3'b100:  alu_ctrl_d = ALU_SLT;
                    3'b101:  alu_ctrl_d = ALU_GE;
                    3'b110:  alu_ctrl_d = ALU_SLTU;
                    3'b111:  alu_ctrl_d = ALU_GEU;
                    default: alu_ctrl_d = ALU_NOP;
                endcase
            end
            OP_LOAD:   begin itype_d = TYPE_I; imm_d = imm_i; alu_src_d = 1'b1; result_src_d = 3'd4; end
            OP_STORE:  begin itype_d = TYPE_S; imm_d = imm_s; alu_src_d = 1'b1; end
            OP_IMM: begin
                itype_d = TYPE_I; imm_d = imm_i; alu_src_d = 1'b1;
                alu_ctrl_d = arith_ctrl(funct3, funct7_5, 1'b0);
            end
            OP_REG:    begin itype_d = TYPE_R; alu_ctrl_d = arith_ctrl(funct3, funct7_5, 1'b1); end
            default:   ;
        endcase
    end

    logic [31:0] op2, alu_d;
    logic [4:0]  shamt;

    assign op2   = alu_src_d ? imm_d : rs2;
    assign shamt = op2[4:0];

    always_comb begin
        alu_d = '0;
        case (alu_ctrl_d)
            ALU_ADD:  alu_d = rs1 + op2;
            ALU_SUB:  alu_d = rs1 - op2;
            ALU_SLL:  alu_d = rs1 << shamt;
            ALU_SLT:  alu_d = {31'd0, $signed(rs1) < $signed(op2)};
            ALU_SLTU: alu_d = {31'd0, rs1 < op2};
            ALU_XOR:  alu_d = rs1 ^ op2;
            ALU_SRL:  alu_d = rs1 >> shamt;
            ALU_SRA:  alu_d = $unsigned($signed(rs1) >>> shamt);
            ALU_OR:   alu_d = rs1 | op2;
            ALU_AND:  alu_d = rs1 & op2;
            ALU_EQ:   alu_d = {31'd0, rs1 == op2};
            ALU_NE:   alu_d = {31'd0, rs1 != op2};
            ALU_GE:   alu_d = {31'd0, $signed(rs1) >= $signed(op2)};
            ALU_GEU:  alu_d = {31'd0, rs1 >= op2};
            default:  alu_d = '0;
        endcase
        // Invalid opcodes decode to ADD but must still present a zero result.
        if (itype_d == TYPE_INV) alu_d = '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all outputs update together.
        if (rst) begin
            out_valid        <= 1'b0;
            alu_result       <= '0;
            imm_ext          <= '0;
            alu_control      <= '0;
            alu_src          <= 1'b0;
            pc_src           <= '0;
            result_src       <= '0;
            instruction_type <= '0;
        end else begin
            out_valid        <= in_valid;
            alu_result       <= alu_d;
            imm_ext          <= imm_d;
            alu_control      <= alu_ctrl_d;
            alu_src          <= alu_src_d;
            pc_src           <= pc_src_d;
            result_src       <= result_src_d;
            instruction_type <= itype_d;
        end
    end

endmodule

// File: tb/tb_decode_execute.sv
// Self-checking bench for decode_execute: an instruction-level model checked every
// cycle, plus literal expectations on hand-decoded instructions.
module tb_decode_execute;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0, rs1 = '0, rs2 = '0;
    logic        out_valid, alu_src;
    logic [31:0] alu_result, imm_ext;
    logic [3:0]  alu_control;
    logic [1:0]  pc_src;
    logic [2:0]  result_src, instruction_type;

    int total = 0;
    int passed = 0;

    decode_execute dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .alu_result(alu_result), .imm_ext(imm_ext),
        .alu_control(alu_control), .alu_src(alu_src), .pc_src(pc_src),
        .result_src(result_src), .instruction_type(instruction_type)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ov;
        logic [31:0] res;
        logic [31:0] imm;
        logic [3:0]  ac;
        logic        as;
        logic [1:0]  ps;
        logic [2:0]  rsrc;
        logic [2:0]  ityp;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        else passed++;
    endtask

    // Instruction-level meaning of one sampled input set.
    function automatic exp_t model(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] ii, x;
        logic [2:0] f3;
        logic alt;
        e = '{ov: v, res: 0, imm: 0, ac: 0, as: 0, ps: 0, rsrc: 0, ityp: 6};
        ii  = $unsigned($signed(i) >>> 20);
        f3  = i[14:12];
        alt = i[30];
        case (i[6:0])
            7'h37: begin e.ityp = 4; e.imm = i & 32'hFFFF_F000; e.rsrc = 1; e.res = a + b; end
            7'h17: begin e.ityp = 4; e.imm = i & 32'hFFFF_F000; e.rsrc = 2; e.res = a + b; end
            7'h6F: begin
                e.ityp = 5; e.ps = 1; e.rsrc = 3;
                e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
                e.res = a + b;
            end
            7'h67: begin e.ityp = 1; e.imm = ii; e.as = 1; e.ps = 2; e.rsrc = 3; e.res = a + ii; end
            7'h03: begin e.ityp = 1; e.imm = ii; e.as = 1; e.rsrc = 4; e.res = a + ii; end
            7'h23: begin e.ityp = 2; e.imm = {ii[31:5], i[11:7]}; e.as = 1; e.res = e.imm + a; end
            7'h63: begin
                e.ityp = 3; e.ps = 3;
                e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
                case (f3)
                    0: begin e.ac = 10; e.res = 32'(a == b); end
                    1: begin e.ac = 11; e.res = 32'(a != b); end
                    4: begin e.ac = 3;  e.res = 32'($signed(a) < $signed(b)); end
                    5: begin e.ac = 12; e.res = 32'(!($signed(a) < $signed(b))); end
                    6: begin e.ac = 4;  e.res = 32'(a < b); end
                    7: begin e.ac = 13; e.res = 32'(!(a < b)); end
                    default: begin e.ac = 14; e.res = 0; end
                endcase
            end
            7'h13, 7'h33: begin
                if (i[6:0] == 7'h13) begin e.ityp = 1; e.imm = ii; e.as = 1; x = ii; end
                else begin e.ityp = 0; x = b; end
                case (f3)
                    0: if (i[6:0] == 7'h33 && alt) begin e.ac = 1; e.res = a - x; end
                       else begin e.ac = 0; e.res = a + x; end
                    1: begin e.ac = 2; e.res = a << (x % 32); end
                    2: begin e.ac = 3; e.res = 32'($signed(a) < $signed(x)); end
                    3: begin e.ac = 4; e.res = 32'(a < x); end
                    4: begin e.ac = 5; e.res = a ^ x; end
                    5: if (alt) begin e.ac = 7; e.res = $unsigned($signed(a) >>> (x % 32)); end
                       else begin e.ac = 6; e.res = a >> (x % 32); end
                    6: begin e.ac = 8; e.res = a | x; end
                    default: begin e.ac = 9; e.res = a & x; end
                endcase
            end
            default: ;
        endcase
        return e;
    endfunction

    exp_t exp_q;
    logic started = 1'b0;

    always @(posedge clk) begin
        if (rst) exp_q = '{ov: 0, res: 0, imm: 0, ac: 0, as: 0, ps: 0, rsrc: 0, ityp: 0};
        else     exp_q = model(in_valid, instr, rs1, rs2);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_out_valid", 32'(out_valid), 32'(exp_q.ov));
            check("m_alu_result", alu_result, exp_q.res);
            check("m_imm_ext", imm_ext, exp_q.imm);
            check("m_alu_control", 32'(alu_control), 32'(exp_q.ac));
            check("m_alu_src", 32'(alu_src), 32'(exp_q.as));
            check("m_pc_src", 32'(pc_src), 32'(exp_q.ps));
            check("m_result_src", 32'(result_src), 32'(exp_q.rsrc));
            check("m_instruction_type", 32'(instruction_type), 32'(exp_q.ityp));
        end
    end

    // Drive one input set, then sample the registered outputs one edge later.
    task automatic apply(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = v; instr = i; rs1 = a; rs2 = b;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] i, a, b;
    } vec_t;

    vec_t vecs[$] = '{
        '{32'h0020_80B3, 32'd10, 32'd20},          // add
        '{32'h0020_B0B3, 32'd1, 32'hFFFF_FFFF},    // sltu
        '{32'h0020_A0B3, 32'd1, 32'hFFFF_FFFF},    // slt
        '{32'h0020_90B3, 32'h0000_0003, 32'd33},   // sll, shift by rs2[4:0]=1
        '{32'h0020_D0B3, 32'h8000_0000, 32'd4},    // srl
        '{32'h4020_D0B3, 32'h8000_0000, 32'd4},    // sra
        '{32'h0020_C0B3, 32'hF0F0_F0F0, 32'hFF00_FF00}, // xor
        '{32'h0020_E0B3, 32'h0F00_0000, 32'h0000_00F0}, // or
        '{32'h0020_F0B3, 32'hFFFF_0000, 32'h0F0F_0F0F}, // and
        '{32'h4010_0093, 32'd3, 32'd0},            // addi with bit30 set: still add
        '{32'h0020_C463, 32'hFFFF_FFFF, 32'd1},    // blt taken
        '{32'h0020_E463, 32'hFFFF_FFFF, 32'd1},    // bltu not taken
        '{32'h0020_D463, 32'd5, 32'd5},            // bge
        '{32'h0020_F463, 32'd4, 32'd5},            // bgeu
        '{32'h0020_1463, 32'd4, 32'd5},            // bne
        '{32'h0020_A463, 32'd4, 32'd5},            // funct3 010: code 14
        '{32'hFFC1_2083, 32'd100, 32'd0},          // lw -4
        '{32'hFE11_2E23, 32'd100, 32'd0},          // sw -4
        '{32'h0040_80E7, 32'd100, 32'd0},          // jalr
        '{32'h1234_5097, 32'd1, 32'd2},            // auipc
        '{32'h8000_00EF, 32'd1, 32'd2}             // jal, negative offset
    };

    initial begin
        apply(1'b1, 32'h0000_0013, 32'd1, 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_type", 32'(instruction_type), 32'd0);
        rst = 1'b0;

        apply(1'b1, 32'hFFF0_0093, 32'd5, 32'd0);
        check("addi_result", alu_result, 32'd4);
        check("addi_imm", imm_ext, 32'hFFFF_FFFF);
        check("addi_alu_src", 32'(alu_src), 32'd1);
        check("addi_type", 32'(instruction_type), 32'd1);
        check("addi_out_valid", 32'(out_valid), 32'd1);

        apply(1'b1, 32'h4020_8033, 32'd3, 32'd5);
        check("sub_result", alu_result, 32'hFFFF_FFFE);
        check("sub_ctrl", 32'(alu_control), 32'd1);

        apply(1'b1, 32'h4040_D093, 32'h8000_0000, 32'd0);
        check("srai_result", alu_result, 32'hF800_0000);
        check("srai_ctrl", 32'(alu_control), 32'd7);

        apply(1'b1, 32'hFE00_0EE3, 32'd7, 32'd7);
        check("beq_imm", imm_ext, 32'hFFFF_FFFC);
        check("beq_ctrl", 32'(alu_control), 32'd10);
        check("beq_result", alu_result, 32'd1);
        check("beq_pc_src", 32'(pc_src), 32'd3);

        apply(1'b0, 32'h1234_50B7, 32'd0, 32'd0);
        check("lui_imm", imm_ext, 32'h1234_5000);
        check("lui_result_src", 32'(result_src), 32'd1);
        check("lui_type", 32'(instruction_type), 32'd4);
        check("lui_out_valid_low", 32'(out_valid), 32'd0);

        apply(1'b1, 32'h0080_00EF, 32'd0, 32'd0);
        check("jal_imm", imm_ext, 32'd8);
        check("jal_pc_src", 32'(pc_src), 32'd1);
        check("jal_result_src", 32'(result_src), 32'd3);

        apply(1'b1, 32'h0000_007F, 32'd1, 32'd2);
        check("invalid_type", 32'(instruction_type), 32'd6);
        check("invalid_result", alu_result, 32'd0);

        apply(1'b1, 32'h0020_A463, 32'd4, 32'd5);
        check("branch_010_ctrl", 32'(alu_control), 32'd14);
        check("branch_010_result", alu_result, 32'd0);

        foreach (vecs[k]) apply(1'(k % 4 != 3), vecs[k].i, vecs[k].a, vecs[k].b);

        rst = 1'b1;
        apply(1'b1, 32'hFFF0_0093, 32'd5, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", alu_result, 32'd0);
        check("rst_imm", imm_ext, 32'd0);
        check("rst_alu_src", 32'(alu_src), 32'd0);
        check("rst_type", 32'(instruction_type), 32'd0);
        rst = 1'b0;

        apply(1'b1, 32'hFFF0_0093, 32'd5, 32'd0);
        check("post_rst_result", alu_result, 32'd4);
        check("post_rst_out_valid", 32'(out_valid), 32'd1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
